// File: rtl/roc_rank_encoder.sv
// roc_rank_encoder: latches an image and emits pixel indices in rank order of intensity, one per busy handshake
module roc_rank_encoder #(
  parameter int IMAGE_SIZE  = 256,
  parameter int PIXEL_BITS  = 8,
  parameter int INDEX_WIDTH = 10,
  parameter int CNT_WIDTH   = $clog2(IMAGE_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IMAGE_SIZE*PIXEL_BITS-1:0] image,
  input  logic                             new_image,
  input  logic                             mode_ascend,
  input  logic [PIXEL_BITS-1:0]            threshold,
  input  logic [CNT_WIDTH-1:0]             max_spikes,
  input  logic                             abort,
  input  logic                             aerin_ctrl_busy,
  output logic [INDEX_WIDTH-1:0]           next_index,
  output logic [PIXEL_BITS-1:0]            next_level,
  output logic                             found_next_index,
  output logic                             encoder_rdy,
  output logic                             encoder_done
);
  localparam int PW = $clog2(IMAGE_SIZE);
  localparam logic [PW-1:0] LAST = PW'(IMAGE_SIZE - 1);
  localparam logic [PIXEL_BITS-1:0] MAXL = {PIXEL_BITS{1'b1}};
  typedef enum logic [2:0] {IDLE, SEARCH, EMIT, WAIT_REL, DONE} state_t;
  state_t state, state_n, adv_state;
  logic [PIXEL_BITS-1:0] pix [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0] thr_q, level, level_n, adv_level, lvl_out_n;
  logic [CNT_WIDTH-1:0] max_q, count, count_n;
  logic [PW-1:0] ptr, ptr_n, adv_ptr;
  logic [INDEX_WIDTH-1:0] index_n;
  logic mode_q, load, wrap, last_lvl, found_n, rdy_n;
  // Scan order: every pixel at one level before stepping the level; end check precedes the step so it never wraps
  always_comb begin
    wrap = ptr == LAST;
    last_lvl = mode_q ? level == MAXL : level == thr_q;
    adv_ptr = wrap ? '0 : ptr + PW'(1);
    adv_level = !wrap ? level : mode_q ? level + PIXEL_BITS'(1) : level - PIXEL_BITS'(1);
    adv_state = wrap && last_lvl ? DONE : SEARCH;
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    level_n = level;
    count_n = count;
    found_n = found_next_index;
    index_n = next_index;
    lvl_out_n = next_level;
    rdy_n = encoder_rdy;
    load = 1'b0;
    case (state)
      IDLE: if (new_image) begin
        load = 1'b1;
        ptr_n = '0;
        count_n = '0;
        level_n = mode_ascend ? threshold : MAXL;
        rdy_n = 1'b0;
        state_n = max_spikes == '0 ? DONE : SEARCH;
      end
      SEARCH: if (pix[ptr] == level) begin
        found_n = 1'b1;
        index_n = INDEX_WIDTH'(ptr);
        lvl_out_n = level;
        state_n = EMIT;
      end else begin
        ptr_n = adv_ptr;
        level_n = adv_level;
        state_n = adv_state;
      end
      EMIT: if (aerin_ctrl_busy) begin
        found_n = 1'b0;
        count_n = count + CNT_WIDTH'(1);
        state_n = WAIT_REL;
      end
      WAIT_REL: if (!aerin_ctrl_busy) begin
        ptr_n = adv_ptr;
        level_n = adv_level;
        state_n = count == max_q ? DONE : adv_state;
      end
      DONE: begin
        state_n = IDLE;
        rdy_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      found_n = 1'b0;
      rdy_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      for (int i = 0; i < IMAGE_SIZE; i++) pix[i] <= '0;
      mode_q <= 1'b0;
      thr_q <= '0;
      max_q <= '0;
      ptr <= '0;
      level <= '0;
      count <= '0;
      next_index <= '0;
      next_level <= '0;
      found_next_index <= 1'b0;
      encoder_rdy <= 1'b1;
      encoder_done <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        for (int i = 0; i < IMAGE_SIZE; i++) pix[i] <= image[i*PIXEL_BITS +: PIXEL_BITS];
        mode_q <= mode_ascend;
        thr_q <= threshold;
        max_q <= max_spikes;
      end
      ptr <= ptr_n;
      level <= level_n;
      count <= count_n;
      next_index <= index_n;
      next_level <= lvl_out_n;
      found_next_index <= found_n;
      encoder_rdy <= rdy_n;
      encoder_done <= state_n == DONE;
    end
endmodule
